// File: rtl/reg_bank_multi_if.sv
`default_nettype none
// ============================================================================
//  Module      : reg_bank_multi_if
//  Description : Bus bundle for the multi-port register bank (read, write,
//                reserve and flush channels).
//  Revision    : 1.0
// ============================================================================
interface reg_bank_multi_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REG    = 32,
    parameter int NUM_READ   = 2,
    parameter int NUM_WRITE  = 1
);
    localparam int SELECT_WIDTH = $clog2(NUM_REG);

    logic [NUM_WRITE-1:0]                   i_write_enable;
    logic [NUM_WRITE-1:0][SELECT_WIDTH-1:0] i_write_select;
    logic [NUM_WRITE-1:0][DATA_WIDTH-1:0]   i_write_data;
    logic [NUM_READ-1:0][SELECT_WIDTH-1:0]  i_read_select;
    logic [NUM_READ-1:0][DATA_WIDTH-1:0]    o_read_data;
    logic [NUM_READ-1:0]                    o_read_busy;
    logic                                   i_reserve_enable;
    logic [SELECT_WIDTH-1:0]                i_reserve_select;
    logic                                   i_flush;
    logic [NUM_REG-1:0]                     o_busy_vector;

    modport master (
        output i_write_enable, i_write_select, i_write_data, i_read_select,
               i_reserve_enable, i_reserve_select, i_flush,
        input  o_read_data, o_read_busy, o_busy_vector
    );

    modport slave (
        input  i_write_enable, i_write_select, i_write_data, i_read_select,
               i_reserve_enable, i_reserve_select, i_flush,
        output o_read_data, o_read_busy, o_busy_vector
    );
endinterface
`default_nettype wire

// File: rtl/reg_bank_multi.sv
`default_nettype none
// ============================================================================
//  Module      : reg_bank_multi
//  Description : Multi-port register bank with optional zero register, write
//                bypass and per-register busy scoreboard.
//  Revision    : 1.0
// ============================================================================
module reg_bank_multi #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REG    = 32,
    parameter int NUM_READ   = 2,
    parameter int NUM_WRITE  = 1,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    reg_bank_multi_if.slave   bus
);
    localparam int SELECT_WIDTH = $clog2(NUM_REG);
    localparam logic [SELECT_WIDTH:0] c_num_reg = (SELECT_WIDTH+1)'(NUM_REG);

    logic [DATA_WIDTH-1:0] r_regs [NUM_REG];
    logic [NUM_REG-1:0]    r_busy;

    logic [NUM_WRITE-1:0]  w_wr_ok;
    logic [NUM_REG-1:0]    w_wr_hit;
    logic [DATA_WIDTH-1:0] w_wr_data [NUM_REG];
    logic [NUM_REG-1:0]    w_rsv_hit;
    logic                  w_rsv_ok;

    // A write port only counts when enabled and aimed at a real, writable register
    for (genvar p = 0; p < NUM_WRITE; p++) begin : g_wport
        assign w_wr_ok[p] = bus.i_write_enable[p]
                          && ({1'b0, bus.i_write_select[p]} < c_num_reg)
                          && !((ZERO_REG != 0) && (bus.i_write_select[p] == '0));
    end

    assign w_rsv_ok = bus.i_reserve_enable
                    && ({1'b0, bus.i_reserve_select} < c_num_reg)
                    && !((ZERO_REG != 0) && (bus.i_reserve_select == '0));

    // Ascending port scan so the highest-numbered port wins a conflict
    always_comb begin
        for (int i = 0; i < NUM_REG; i++) begin
            w_wr_hit[i]  = 1'b0;
            w_wr_data[i] = '0;
            w_rsv_hit[i] = w_rsv_ok && (bus.i_reserve_select == SELECT_WIDTH'(i));
            for (int p = 0; p < NUM_WRITE; p++) begin
                if (w_wr_ok[p] && (bus.i_write_select[p] == SELECT_WIDTH'(i))) begin
                    w_wr_hit[i]  = 1'b1;
                    w_wr_data[i] = bus.i_write_data[p];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REG; i++) begin
                r_regs[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            for (int i = 0; i < NUM_REG; i++) begin
                if (w_wr_hit[i]) begin
                    r_regs[i] <= w_wr_data[i];
                end
            end
            // A same-cycle reserve is a newer producer, so it overrides the clear
            if (bus.i_flush) begin
                r_busy <= '0;
            end else begin
                r_busy <= (r_busy & ~w_wr_hit) | w_rsv_hit;
            end
        end
    end

    assign bus.o_busy_vector = r_busy;

    for (genvar r = 0; r < NUM_READ; r++) begin : g_rport
        logic [SELECT_WIDTH-1:0] w_sel;
        logic                    w_ok;
        logic [DATA_WIDTH-1:0]   w_data;
        logic                    w_busy;

        assign w_sel = bus.i_read_select[r];
        assign w_ok  = ({1'b0, w_sel} < c_num_reg)
                     && !((ZERO_REG != 0) && (w_sel == '0));

        always_comb begin
            w_data = '0;
            w_busy = 1'b0;
            if (w_ok) begin
                if ((BYPASS != 0) && w_wr_hit[w_sel]) begin
                    w_data = w_wr_data[w_sel];
                    w_busy = 1'b0;
                end else begin
                    w_data = r_regs[w_sel];
                    w_busy = r_busy[w_sel];
                end
            end
        end

        assign bus.o_read_data[r] = w_data;
        assign bus.o_read_busy[r] = w_busy;
    end
endmodule
`default_nettype wire

// File: tb/tb_reg_bank_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_bank_multi
//  Description : Scoreboard bench for two bank configurations driven in
//                lockstep (A: 24 regs, zero reg, bypass; B: 32 regs, neither).
//  Revision    : 1.0
// ============================================================================
module tb_reg_bank_multi;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    reg_bank_multi_if #(.DATA_WIDTH(32), .NUM_REG(24), .NUM_READ(2), .NUM_WRITE(2)) bus_a ();
    reg_bank_multi_if #(.DATA_WIDTH(32), .NUM_REG(32), .NUM_READ(2), .NUM_WRITE(2)) bus_b ();

    reg_bank_multi #(.DATA_WIDTH(32), .NUM_REG(24), .NUM_READ(2), .NUM_WRITE(2),
                     .ZERO_REG(1), .BYPASS(1)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    reg_bank_multi #(.DATA_WIDTH(32), .NUM_REG(32), .NUM_READ(2), .NUM_WRITE(2),
                     .ZERO_REG(0), .BYPASS(0)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    typedef struct packed {
        logic [1:0]  dut;
        logic [1:0]  kind;
        logic [1:0]  port;
        logic [31:0] val;
    } chk_t;

    localparam logic [1:0] c_da = 2'd0, c_db = 2'd1;
    localparam logic [1:0] c_data = 2'd0, c_rbusy = 2'd1, c_bvec = 2'd2;

    chk_t  exp_q[$];
    string name_q[$];
    int    n_total = 0;
    int    n_pass  = 0;

    task automatic expect_chk(input logic [1:0] d, input logic [1:0] k, input logic [1:0] p,
                              input logic [31:0] v, input string nm);
        chk_t c;
        c.dut = d; c.kind = k; c.port = p; c.val = v;
        exp_q.push_back(c);
        name_q.push_back(nm);
    endtask

    task automatic drive(input logic we0, input logic [4:0] ws0, input logic [31:0] wd0,
                         input logic we1, input logic [4:0] ws1, input logic [31:0] wd1,
                         input logic [4:0] rs0, input logic [4:0] rs1,
                         input logic re, input logic [4:0] rsel, input logic fl);
        bus_a.i_write_enable = {we1, we0};  bus_b.i_write_enable = {we1, we0};
        bus_a.i_write_select = {ws1, ws0};  bus_b.i_write_select = {ws1, ws0};
        bus_a.i_write_data   = {wd1, wd0};  bus_b.i_write_data   = {wd1, wd0};
        bus_a.i_read_select  = {rs1, rs0};  bus_b.i_read_select  = {rs1, rs0};
        bus_a.i_reserve_enable = re;        bus_b.i_reserve_enable = re;
        bus_a.i_reserve_select = rsel;      bus_b.i_reserve_select = rsel;
        bus_a.i_flush = fl;                 bus_b.i_flush = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] actual(input logic [1:0] d, input logic [1:0] k, input logic [1:0] p);
        logic [31:0] r;
        r = '0;
        if (d == c_da) begin
            case (k)
                c_data:  r = bus_a.o_read_data[p[0]];
                c_rbusy: r = {31'b0, bus_a.o_read_busy[p[0]]};
                default: r = {8'b0, bus_a.o_busy_vector};
            endcase
        end else begin
            case (k)
                c_data:  r = bus_b.o_read_data[p[0]];
                c_rbusy: r = {31'b0, bus_b.o_read_busy[p[0]]};
                default: r = bus_b.o_busy_vector;
            endcase
        end
        return r;
    endfunction

    // Monitor: drains the scoreboard on every falling edge
    initial begin
        chk_t        c;
        string       nm;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                c   = exp_q.pop_front();
                nm  = name_q.pop_front();
                act = actual(c.dut, c.kind, c.port);
                n_total++;
                if (act === c.val) n_pass++;
                else $display("FAIL %s dut=%s got 0x%08h expected 0x%08h",
                              nm, (c.dut == c_da) ? "A" : "B", act, c.val);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0);
        step();
        expect_chk(c_da, c_bvec, 0, 32'h0, "reset_bvec");
        expect_chk(c_db, c_bvec, 0, 32'h0, "reset_bvec");
        expect_chk(c_da, c_data, 0, 32'h0, "reset_rd5");
        step();
        rst_n = 1'b1;

        // Write r5; bypass shows it immediately on A only
        step(); drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0, 0, 0, 0);
        expect_chk(c_da, c_data, 0, 32'hDEADBEEF, "wr5_bypass");
        expect_chk(c_db, c_data, 0, 32'h0,        "wr5_nobypass");
        step(); drive(0, 0, 0, 0, 0, 0, 5, 6, 0, 0, 0);
        expect_chk(c_da, c_data, 0, 32'hDEADBEEF, "rd5_after");
        expect_chk(c_db, c_data, 0, 32'hDEADBEEF, "rd5_after");

        // Asynchronous reset mid-cycle with a write to r6 pending
        step(); drive(0, 0, 0, 1, 6, 32'h1111, 5, 6, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        expect_chk(c_da, c_data, 0, 32'h0, "async_rst_rd5");
        expect_chk(c_db, c_data, 0, 32'h0, "async_rst_rd5");
        expect_chk(c_db, c_bvec, 0, 32'h0, "async_rst_bvec");
        step(); rst_n = 1'b1; drive(0, 0, 0, 0, 0, 0, 5, 6, 0, 0, 0);
        expect_chk(c_da, c_data, 1, 32'h0, "rst_blocks_wr6");
        expect_chk(c_db, c_data, 1, 32'h0, "rst_blocks_wr6");

        step(); drive(1, 3, 32'h1234, 0, 0, 0, 0, 3, 0, 0, 0);
        expect_chk(c_da, c_data, 1, 32'h1234, "bypass_r3");
        expect_chk(c_db, c_data, 1, 32'h0,    "nobypass_r3");
        step(); drive(0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0);
        expect_chk(c_da, c_data, 1, 32'h1234, "r3_after");
        expect_chk(c_db, c_data, 1, 32'h1234, "r3_after");

        // Both ports target r7: port1 wins
        step(); drive(1, 7, 32'hAAAA, 1, 7, 32'h5555, 7, 0, 0, 0, 0);
        expect_chk(c_da, c_data, 0, 32'h5555, "conflict_bypass");
        expect_chk(c_db, c_data, 0, 32'h0,    "conflict_old");
        step(); drive(0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0);
        expect_chk(c_da, c_data, 0, 32'h5555, "conflict_r7");
        expect_chk(c_db, c_data, 0, 32'h5555, "conflict_r7");

        // Zero register: write and reserve r0
        step(); drive(1, 0, 32'hFFFF, 0, 0, 0, 0, 0, 1, 0, 0);
        expect_chk(c_da, c_data,  0, 32'h0, "zero_rd_same");
        expect_chk(c_da, c_rbusy, 0, 32'h0, "zero_rbusy_same");
        step(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_chk(c_da, c_data,  0, 32'h0,    "zero_rd");
        expect_chk(c_db, c_data,  0, 32'hFFFF, "nozero_rd");
        expect_chk(c_da, c_bvec,  0, 32'h0,    "zero_bvec");
        expect_chk(c_db, c_bvec,  0, 32'h1,    "nozero_bvec");
        expect_chk(c_da, c_rbusy, 0, 32'h0,    "zero_rbusy");
        expect_chk(c_db, c_rbusy, 0, 32'h1,    "nozero_rbusy");
        step(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Scoreboard on r9
        step(); drive(0, 0, 0, 0, 0, 0, 9, 0, 1, 9, 0);
        expect_chk(c_da, c_rbusy, 0, 32'h0, "rsv_not_same_cycle");
        expect_chk(c_db, c_bvec,  0, 32'h0, "flush_cleared_r0");
        step(); drive(0, 0, 0, 0, 0, 0, 9, 0, 0, 0, 0);
        expect_chk(c_da, c_bvec,  0, 32'h200, "rsv9_bvec");
        expect_chk(c_db, c_bvec,  0, 32'h200, "rsv9_bvec");
        expect_chk(c_da, c_rbusy, 0, 32'h1,   "rsv9_rbusy");
        step(); drive(1, 9, 32'h42, 0, 0, 0, 9, 0, 0, 0, 0);
        expect_chk(c_da, c_rbusy, 0, 32'h0,  "wr9_bypass_rbusy");
        expect_chk(c_da, c_data,  0, 32'h42, "wr9_bypass_data");
        expect_chk(c_db, c_rbusy, 0, 32'h1,  "wr9_nobypass_rbusy");
        step(); drive(0, 0, 0, 0, 0, 0, 9, 0, 0, 0, 0);
        expect_chk(c_da, c_bvec, 0, 32'h0,  "wr9_cleared");
        expect_chk(c_db, c_bvec, 0, 32'h0,  "wr9_cleared");
        expect_chk(c_db, c_data, 0, 32'h42, "wr9_data");
        step(); drive(0, 0, 0, 1, 9, 32'h43, 9, 0, 1, 9, 0);
        step(); drive(0, 0, 0, 0, 0, 0, 9, 0, 0, 0, 0);
        expect_chk(c_da, c_bvec, 0, 32'h200, "rsv_beats_clear");
        expect_chk(c_db, c_bvec, 0, 32'h200, "rsv_beats_clear");
        expect_chk(c_da, c_data, 0, 32'h43,  "rsv_wr_data");

        // Flush overrides a same-cycle reserve
        step(); drive(0, 0, 0, 0, 0, 0, 0, 9, 1, 2, 0);
        step(); drive(0, 0, 0, 0, 0, 0, 0, 9, 1, 4, 0);
        expect_chk(c_da, c_bvec, 0, 32'h204, "rsv2_bvec");
        step(); drive(0, 0, 0, 0, 0, 0, 0, 9, 1, 6, 1);
        expect_chk(c_da, c_bvec, 0, 32'h214, "pre_flush_bvec");
        step(); drive(0, 0, 0, 0, 0, 0, 30, 9, 0, 0, 0);
        expect_chk(c_da, c_bvec, 0, 32'h0,  "flush_bvec");
        expect_chk(c_db, c_bvec, 0, 32'h0,  "flush_bvec");
        expect_chk(c_da, c_data, 0, 32'h0,  "oor_rd30");
        expect_chk(c_da, c_data, 1, 32'h43, "rd9_kept");

        // Out-of-range write/reserve on A (in range on B)
        step(); drive(1, 30, 32'hBAD, 1, 23, 32'h77, 30, 23, 1, 30, 0);
        expect_chk(c_da, c_data,  0, 32'h0,  "oor_bypass_rd30");
        expect_chk(c_da, c_data,  1, 32'h77, "bypass_r23");
        step(); drive(0, 0, 0, 0, 0, 0, 30, 6, 0, 0, 0);
        expect_chk(c_da, c_data,  0, 32'h0,        "oor_wr30");
        expect_chk(c_db, c_data,  0, 32'hBAD,      "inrange_wr30");
        expect_chk(c_da, c_bvec,  0, 32'h0,        "oor_rsv30");
        expect_chk(c_db, c_bvec,  0, 32'h40000000, "inrange_rsv30");
        expect_chk(c_da, c_rbusy, 0, 32'h0,        "oor_rbusy");
        expect_chk(c_da, c_data,  1, 32'h0,        "no_alias_r6");
        step(); drive(0, 0, 0, 0, 0, 0, 23, 0, 0, 0, 0);
        expect_chk(c_da, c_data, 0, 32'h77, "r23_after");
        expect_chk(c_db, c_data, 0, 32'h77, "r23_after");

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL scoreboard_drain left=%0d expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/reg_bank_multi.md
Name: reg_bank_multi

Overview:
Multi-port register bank: the generalised successor to the single-port bank.
- Provides NUM_READ independent combinational read ports and NUM_WRITE synchronous write ports.
- Optional hardwired-zero register 0 and optional write-to-read bypass.
- Per-register busy scoreboard (reserve / write-clear / flush) for the pipeline's hazard logic.
- Sits between decode (reads, reserves) and writeback (writes) of the core.

Parameters:
DATA_WIDTH, 32, register width in bits
NUM_REG, 32, number of registers (>=2); SELECT_WIDTH = $clog2(NUM_REG) is a localparam
NUM_READ, 2, number of read ports (>=1)
NUM_WRITE, 1, number of write ports (>=1)
ZERO_REG, 1, 1 = register 0 always reads 0, ignores writes and reserves
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-low
i_write_enable  input  [NUM_WRITE]  per-port write strobe
i_write_select  input  [NUM_WRITE][SELECT_WIDTH]  per-port destination index
i_write_data  input  [NUM_WRITE][DATA_WIDTH]  per-port write data
i_read_select  input  [NUM_READ][SELECT_WIDTH]  per-port source index
o_read_data  output  [NUM_READ][DATA_WIDTH]  per-port read data (combinational)
o_read_busy  output  [NUM_READ]  source register has a pending producer (combinational)
i_reserve_enable  input  1  mark a register busy
i_reserve_select  input  [SELECT_WIDTH]  register to reserve
i_flush  input  1  clear every busy bit
o_busy_vector  output  [NUM_REG]  registered busy bits, bit i = register i

Behaviour:
- Reset (rst_n low, asynchronous): all data registers clear to 0; all busy bits clear to 0.
  - o_busy_vector = 0 immediately.
  - o_read_data = 0 for every in-range select; o_read_busy = 0.
  - Reset asserted mid-operation overrides any write, reserve or flush in that cycle.
- Write: at a rising edge, each port p with i_write_enable[p]=1 and i_write_select[p] < NUM_REG stores i_write_data[p].
  - Out-of-range selects are ignored.
  - With ZERO_REG=1, writes to index 0 are ignored.
  - Two or more ports targeting the same register in one cycle: the highest-numbered port wins.
- Read: o_read_data[r] is combinational from i_read_select[r].
  - Out-of-range select returns 0, never X.
  - ZERO_REG=1 and select 0 returns 0.
  - BYPASS=1: if any enabled, valid write port targets the read index this cycle, return that write data (highest port wins). Zero-register and out-of-range rules take precedence over bypass.
  - BYPASS=0: read returns the stored value; the new value is visible the cycle after the edge.
- Busy scoreboard, evaluated per register at each edge:
  - i_flush=1: all busy bits become 0. Flush overrides reserve and write-clear; data writes still occur.
  - Otherwise, reserve hit (i_reserve_enable and i_reserve_select == i): busy=1. Reserve wins over a same-cycle write-clear of the same register, because it represents a new producer.
  - Otherwise, any enabled valid write to i: busy=0.
  - Otherwise: hold.
  - Reserves that are out of range, or to index 0 with ZERO_REG=1, are ignored.
- o_read_busy[r] = busy[sel] AND NOT (BYPASS=1 AND a same-cycle write hits sel).
  - 0 for out-of-range selects and for the zero register.
  - It does not reflect a same-cycle reserve; that is visible next cycle.
- o_busy_vector is the registered busy state; bit 0 is constant 0 when ZERO_REG=1.
- Latency:
  - Write-to-read: 0 cycles with BYPASS, 1 cycle without.
  - Reserve/clear to busy visible: 1 cycle.

Test Plan:
- Reset: write 0xDEADBEEF to r5, assert rst_n=0 between clock edges -> o_read_data for r5 = 0 immediately; o_busy_vector = 0.
- Bypass: BYPASS=1, write port0 r3 = 0x1234 and read port1 sel=3 in the same cycle -> o_read_data[1]=0x1234 before the edge and it holds after. BYPASS=0 -> old value 0 before the edge, 0x1234 after.
- Write conflict: NUM_WRITE=2, port0 r7=0xAAAA, port1 r7=0x5555 same cycle -> r7 reads 0x5555.
- Zero register: ZERO_REG=1, write r0=0xFFFF and reserve r0 -> reads 0, o_busy_vector[0]=0, o_read_busy=0. ZERO_REG=0 -> reads 0xFFFF.
- Scoreboard: reserve r9 -> next cycle o_busy_vector[9]=1.
  - Reading r9 -> o_read_busy=1.
  - Write r9=0x42 (BYPASS=1) -> o_read_busy=0 and data=0x42 that cycle; busy clears after the edge.
  - Reserve and write r9 in the same cycle -> busy stays 1.
- Flush / out-of-range: NUM_REG=24, reserve r2 then r4, then i_flush with reserve r6 -> o_busy_vector=0. Read sel=30 -> data 0. Write sel=30 -> no register changes.
